// File: rtl/rvmcu_soc_pkg.sv
// Shared encodings for the RVMCU I/O subsystem: switch command fields,
// pad ranges of the three GPIO ports and interrupt bit positions.
package rvmcu_soc_pkg;

    localparam logic [1:0] SEL_A   = 2'd0;
    localparam logic [1:0] SEL_B   = 2'd1;
    localparam logic [1:0] SEL_C   = 2'd2;
    localparam logic [1:0] SEL_IRQ = 2'd3;

    localparam logic REG_DIR  = 1'b0;
    localparam logic REG_OUT  = 1'b1;
    localparam logic REG_MASK = 1'b0;
    localparam logic REG_W1C  = 1'b1;

    localparam int PORT_W    = 8;
    localparam int PORT_A_LO = 16;
    localparam int PORT_B_LO = 8;
    localparam int PORT_C_LO = 0;

    localparam int SW_STRB   = 15;
    localparam int SW_SEL_LO = 13;
    localparam int SW_REG    = 12;

    localparam int IRQ_EXT  = 0;
    localparam int IRQ_SOFT = 1;
    localparam int IRQ_GPIO = 2;
    localparam int NIRQ     = 3;

endpackage

// File: rtl/rvmcu_soc_gpio.sv
// GPIO port slice (direction/output registers, input synchroniser, change
// detect) and the wrapper that ties three slices to the tri-state pad bus.
module gpio_port #(
    parameter int PW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_dir,
    input  logic          wr_out,
    input  logic [PW-1:0] wdata,
    input  logic [PW-1:0] pad_i,
    input  logic          det_en,
    output logic [PW-1:0] dir_o,
    output logic [PW-1:0] out_o,
    output logic [PW-1:0] in_s_o,
    output logic          chg_o
);

    logic [PW-1:0] reg_dir_ff, reg_dir_d;
    logic [PW-1:0] out_q, out_d;
    logic [PW-1:0] prev_q, prev_d;
    logic [PW-1:0] sync_q  [SYNC_STAGES];
    logic [PW-1:0] sync_d  [SYNC_STAGES];
    logic [PW-1:0] dhist_q [SYNC_STAGES+1];
    logic [PW-1:0] dhist_d [SYNC_STAGES+1];
    logic [PW-1:0] dir_any;

    always_comb begin
        reg_dir_d = wr_dir ? wdata : reg_dir_ff;
        out_d     = wr_out ? wdata : out_q;
        sync_d[0] = pad_i;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
        prev_d     = sync_q[SYNC_STAGES-1];
        dhist_d[0] = reg_dir_ff;
        for (int k = 1; k <= SYNC_STAGES; k++) dhist_d[k] = dhist_q[k-1];
        // A pin counts as input only if it was an input for the whole time its
        // value has been travelling through the synchroniser.
        dir_any = reg_dir_ff;
        for (int k = 0; k <= SYNC_STAGES; k++) dir_any = dir_any | dhist_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_dir_ff <= '0;
            out_q      <= '0;
            prev_q     <= '0;
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int k = 0; k <= SYNC_STAGES; k++) dhist_q[k] <= '0;
        end else begin
            reg_dir_ff <= reg_dir_d;
            out_q      <= out_d;
            prev_q     <= prev_d;
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
            for (int k = 0; k <= SYNC_STAGES; k++) dhist_q[k] <= dhist_d[k];
        end
    end

    assign dir_o  = reg_dir_ff;
    assign out_o  = out_q;
    assign in_s_o = sync_q[SYNC_STAGES-1];
    assign chg_o  = det_en & (|((sync_q[SYNC_STAGES-1] ^ prev_q) & ~dir_any));

endmodule

module gpio_top
    import rvmcu_soc_pkg::*;
#(
    parameter int NPORT       = 3,
    parameter int PW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                det_en,
    input  logic [NPORT-1:0]    wr_dir,
    input  logic [NPORT-1:0]    wr_out,
    input  logic [PW-1:0]       wdata,
    inout  wire  [NPORT*PW-1:0] gpio_io,
    output logic [NPORT*PW-1:0] in_s_o,
    output logic                chg_o
);

    logic [NPORT*PW-1:0] dir_all;
    logic [NPORT*PW-1:0] out_all;
    logic [NPORT-1:0]    chg;

    gpio_port #(.PW(PW), .SYNC_STAGES(SYNC_STAGES)) gpio_A (
        .clk(clk), .rst(rst), .wr_dir(wr_dir[0]), .wr_out(wr_out[0]), .wdata(wdata),
        .pad_i(gpio_io[PORT_A_LO +: PW]), .det_en(det_en),
        .dir_o(dir_all[PORT_A_LO +: PW]), .out_o(out_all[PORT_A_LO +: PW]),
        .in_s_o(in_s_o[PORT_A_LO +: PW]), .chg_o(chg[0])
    );

    gpio_port #(.PW(PW), .SYNC_STAGES(SYNC_STAGES)) gpio_B (
        .clk(clk), .rst(rst), .wr_dir(wr_dir[1]), .wr_out(wr_out[1]), .wdata(wdata),
        .pad_i(gpio_io[PORT_B_LO +: PW]), .det_en(det_en),
        .dir_o(dir_all[PORT_B_LO +: PW]), .out_o(out_all[PORT_B_LO +: PW]),
        .in_s_o(in_s_o[PORT_B_LO +: PW]), .chg_o(chg[1])
    );

    gpio_port #(.PW(PW), .SYNC_STAGES(SYNC_STAGES)) gpio_C (
        .clk(clk), .rst(rst), .wr_dir(wr_dir[2]), .wr_out(wr_out[2]), .wdata(wdata),
        .pad_i(gpio_io[PORT_C_LO +: PW]), .det_en(det_en),
        .dir_o(dir_all[PORT_C_LO +: PW]), .out_o(out_all[PORT_C_LO +: PW]),
        .in_s_o(in_s_o[PORT_C_LO +: PW]), .chg_o(chg[2])
    );

    for (genvar i = 0; i < NPORT*PW; i++) begin : g_pad
        assign gpio_io[i] = dir_all[i] ? out_all[i] : 1'bz;
    end

    assign chg_o = |chg;

endmodule

// File: rtl/rvmcu_soc_top.sv
// RVMCU I/O subsystem top: switch-driven register writes, interrupt
// pending/enable and the LED status mux around the three GPIO ports.
module rvmcu_soc_top
    import rvmcu_soc_pkg::*;
#(
    parameter int NPORT       = 3,
    parameter int PW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                irq_ext_i,
    input  logic                irq_soft_i,
    inout  wire  [NPORT*PW-1:0] gpio_io,
    input  logic [15:0]         gp_switch_i,
    output logic [15:0]         gp_led_o
);

    logic [15:0]      sw_sync_q  [SYNC_STAGES];
    logic [15:0]      sw_sync_d  [SYNC_STAGES];
    logic [1:0]       irq_sync_q [SYNC_STAGES];
    logic [1:0]       irq_sync_d [SYNC_STAGES];
    logic             strb_prev_q, strb_prev_d;
    logic [1:0]       irq_prev_q, irq_prev_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [NIRQ-1:0]  mask_q, mask_d;
    logic [NIRQ-1:0]  pend_q, pend_d;
    logic [15:0]      led_q, led_d;

    logic [15:0]         sw_s;
    logic [1:0]          irq_s;
    logic                fire;
    logic [1:0]          sel;
    logic                regb;
    logic [PW-1:0]       wdata;
    logic [NPORT-1:0]    wr_dir, wr_out;
    logic [NIRQ-1:0]     clr, set;
    logic [PW-1:0]       mux;
    logic [NPORT*PW-1:0] in_s;
    logic                chg;
    logic                unused_sw;

    always_comb begin
        sw_sync_d[0]  = gp_switch_i;
        irq_sync_d[0] = {irq_soft_i, irq_ext_i};
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sw_sync_d[k]  = sw_sync_q[k-1];
            irq_sync_d[k] = irq_sync_q[k-1];
        end
        sw_s        = sw_sync_q[SYNC_STAGES-1];
        irq_s       = irq_sync_q[SYNC_STAGES-1];
        strb_prev_d = sw_s[SW_STRB];
        irq_prev_d  = irq_s;
        unused_sw   = ^sw_s[11:8];

        // Edge detection stays off until the synchronisers hold real pad
        // values, so levels already high at reset release never fire.
        cnt_d   = ready_q ? cnt_q : cnt_q + 4'd1;
        ready_d = ready_q | (cnt_q == 4'(SYNC_STAGES));

        fire  = ready_q & sw_s[SW_STRB] & ~strb_prev_q;
        sel   = sw_s[SW_SEL_LO +: 2];
        regb  = sw_s[SW_REG];
        wdata = sw_s[PW-1:0];

        wr_dir = '0;
        wr_out = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (fire && sel == 2'(p)) begin
                wr_dir[p] = (regb == REG_DIR);
                wr_out[p] = (regb == REG_OUT);
            end
        end

        mask_d = mask_q;
        clr    = '0;
        if (fire && sel == SEL_IRQ) begin
            if (regb == REG_MASK) mask_d = wdata[NIRQ-1:0];
            else                  clr    = wdata[NIRQ-1:0];
        end

        set           = '0;
        set[IRQ_EXT]  = ready_q & irq_s[IRQ_EXT]  & ~irq_prev_q[IRQ_EXT];
        set[IRQ_SOFT] = ready_q & irq_s[IRQ_SOFT] & ~irq_prev_q[IRQ_SOFT];
        set[IRQ_GPIO] = chg;
        pend_d        = (pend_q & ~clr) | set;

        case (sel)
            SEL_A:   mux = in_s[PORT_A_LO +: PW];
            SEL_B:   mux = in_s[PORT_B_LO +: PW];
            SEL_C:   mux = in_s[PORT_C_LO +: PW];
            default: mux = {{(PW-NIRQ){1'b0}}, mask_q};
        endcase
        led_d = {|(pend_q & mask_q), 4'b0000, pend_q, mux};
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sw_sync_q[k]  <= '0;
                irq_sync_q[k] <= '0;
            end
            strb_prev_q <= 1'b0;
            irq_prev_q  <= '0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            mask_q      <= '0;
            pend_q      <= '0;
            led_q       <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sw_sync_q[k]  <= sw_sync_d[k];
                irq_sync_q[k] <= irq_sync_d[k];
            end
            strb_prev_q <= strb_prev_d;
            irq_prev_q  <= irq_prev_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            mask_q      <= mask_d;
            pend_q      <= pend_d;
            led_q       <= led_d;
        end
    end

    gpio_top #(.NPORT(NPORT), .PW(PW), .SYNC_STAGES(SYNC_STAGES)) gpio_top_module (
        .clk(clk), .rst(rst_n), .det_en(ready_q),
        .wr_dir(wr_dir), .wr_out(wr_out), .wdata(wdata),
        .gpio_io(gpio_io), .in_s_o(in_s), .chg_o(chg)
    );

    assign gp_led_o = led_q;

endmodule

// File: tb/tb_rvmcu_soc_top.sv
// Scoreboard bench for rvmcu_soc_top: stimulus pushes expectations from a
// register-level model, a negedge monitor pops and compares them.
module tb_rvmcu_soc_top;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        irq_ext = 1'b0;
    logic        irq_soft = 1'b0;
    logic [15:0] sw = 16'h0000;
    wire  [15:0] led;
    wire  [23:0] gpio_io;
    logic [23:0] tb_drv = 24'h0;
    logic [23:0] tb_oe = 24'hFFFFFF;

    for (genvar i = 0; i < 24; i++) begin : g_bench_pad
        assign gpio_io[i] = tb_oe[i] ? tb_drv[i] : 1'bz;
    end

    rvmcu_soc_top dut (
        .clk(clk), .rst_n(rst_n), .irq_ext_i(irq_ext), .irq_soft_i(irq_soft),
        .gpio_io(gpio_io), .gp_switch_i(sw), .gp_led_o(led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wire [23:0] dir_probe = {dut.gpio_top_module.gpio_A.reg_dir_ff,
                             dut.gpio_top_module.gpio_B.reg_dir_ff,
                             dut.gpio_top_module.gpio_C.reg_dir_ff};

    typedef struct {
        int          kind;   // 0 = LEDs, 1 = pads, 2 = direction registers
        int          due;
        logic [23:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        chk_t        c;
        logic [23:0] act;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            c = sb.pop_front();
            case (c.kind)
                0:       act = {8'h00, led};
                1:       act = gpio_io;
                default: act = dir_probe;
            endcase
            n_cmp++;
            if (act !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h (cycle %0d)", c.name, act, c.exp, cyc);
            end
        end
    end

    // Register-level model: port index 0=A, 1=B, 2=C
    logic [7:0] m_dir[3], m_out[3], m_bench[3];
    logic [2:0] m_mask, m_pend;
    logic [1:0] m_sel;

    function automatic logic [7:0] pad_of(int p);
        return (m_dir[p] & m_out[p]) | (~m_dir[p] & m_bench[p]);
    endfunction

    function automatic logic [15:0] led_exp();
        logic [7:0] v;
        v = (m_sel == 2'd3) ? {5'b0, m_mask} : pad_of(int'(m_sel));
        return {|(m_pend & m_mask), 4'b0000, m_pend, v};
    endfunction

    function automatic logic [23:0] pads_exp();
        return {pad_of(0), pad_of(1), pad_of(2)};
    endfunction

    function automatic logic [23:0] dirs_exp();
        return {m_dir[0], m_dir[1], m_dir[2]};
    endfunction

    task automatic push(int kind, int due, logic [23:0] exp, string name);
        chk_t c;
        c.kind = kind;
        c.due  = due;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle_check(string name);
        wait_cyc(6);
        push(0, cyc, {8'h00, led_exp()}, name);
        push(1, cyc, pads_exp(), {name, "_pad"});
        wait_cyc(1);
    endtask

    task automatic apply_bench();
        tb_drv = {m_bench[0], m_bench[1], m_bench[2]};
    endtask

    task automatic set_oe(int p, logic [7:0] v);
        tb_oe[(2-p)*8 +: 8] = v;
    endtask

    task automatic bench_set(int p, logic [7:0] v);
        if (((v ^ m_bench[p]) & ~m_dir[p]) != 8'h00) m_pend[2] = 1'b1;
        m_bench[p] = v;
        apply_bench();
    endtask

    task automatic set_sel(logic [1:0] s);
        sw[14:13] = s;
        m_sel     = s;
    endtask

    task automatic sw_write(logic [1:0] sel, logic rb, logic [7:0] data, bit with_irq);
        logic [23:0] old_dirs;
        old_dirs = dirs_exp();
        sw = {1'b0, sel, rb, 4'($urandom), data};
        wait_cyc(2);
        sw[15] = 1'b1;
        if (with_irq) irq_ext = 1'b1;
        m_sel = sel;
        if (sel == 2'd3) begin
            if (rb == 1'b0) m_mask = data[2:0];
            else            m_pend = m_pend & ~data[2:0];
            if (with_irq)   m_pend[0] = 1'b1;
        end else if (rb == 1'b0) begin
            m_dir[sel] = data;
            push(2, cyc + 2, old_dirs, "wr_dir_early");
            push(2, cyc + 3, dirs_exp(), "wr_dir_land");
        end else begin
            m_out[sel] = data;
        end
        wait_cyc(4);
        sw[15] = 1'b0;
        wait_cyc(3);
    endtask

    // Bench hand-over: pins about to change owner are first driven by both
    // sides with the same value, so no pin ever floats or fights.
    task automatic cfg_dir(int p, logic [7:0] nd);
        logic [7:0] up, down;
        up   = nd & ~m_dir[p];
        down = m_dir[p] & ~nd;
        bench_set(p, (m_bench[p] & ~(up | down)) | (m_out[p] & (up | down)));
        set_oe(p, ~m_dir[p] | down);
        wait_cyc(6);
        sw_write(2'(p), 1'b0, nd, 1'b0);
        set_oe(p, ~nd);
    endtask

    task automatic pulse_irq(int which);
        if (which == 1) irq_soft = 1'b1;
        else            irq_ext  = 1'b1;
        wait_cyc(3);
        irq_soft = 1'b0;
        irq_ext  = 1'b0;
        m_pend[which] = 1'b1;
    endtask

    initial begin
        int guard;
        for (int p = 0; p < 3; p++) begin
            m_dir[p] = 8'h00;
            m_out[p] = 8'h00;
        end
        m_bench[0] = 8'h00;
        m_bench[1] = 8'hFF;
        m_bench[2] = 8'h00;
        m_mask = 3'b000;
        m_pend = 3'b000;
        m_sel  = 2'd0;
        apply_bench();

        #1 rst_n = 1'b1;
        #1;
        push(0, 0, 24'h0, "rst_led");
        push(2, 0, 24'h0, "rst_dir");
        #9 rst_n = 1'b0;
        wait_cyc(2);

        set_sel(2'd1);
        settle_check("rd_B_FF");
        bench_set(1, 8'hAA);
        settle_check("rd_B_AA");

        sw_write(2'd3, 1'b1, 8'h04, 1'b0);
        settle_check("clr_gpio");
        cfg_dir(0, 8'hFF);
        sw_write(2'd0, 1'b1, 8'h5A, 1'b0);
        settle_check("out_A_5A");

        cfg_dir(2, 8'h0F);
        sw_write(2'd2, 1'b1, 8'hAA, 1'b0);
        bench_set(2, 8'hB0);
        settle_check("mixed_C");

        sw_write(2'd3, 1'b1, 8'h07, 1'b0);
        sw_write(2'd3, 1'b0, 8'h07, 1'b0);
        pulse_irq(0);
        settle_check("irq_ext");
        sw_write(2'd3, 1'b1, 8'h01, 1'b0);
        settle_check("irq_clr");
        sw_write(2'd3, 1'b1, 8'h01, 1'b1);
        irq_ext = 1'b0;
        settle_check("irq_set_wins");
        irq_soft = 1'b1;
        m_pend[1] = 1'b1;
        settle_check("soft_set");
        sw_write(2'd3, 1'b1, 8'h03, 1'b0);
        settle_check("soft_once");
        irq_soft = 1'b0;
        settle_check("soft_low");

        for (int i = 0; i < 60; i++) begin
            int p;
            p = $urandom_range(0, 2);
            case ($urandom_range(0, 6))
                0:       set_sel(2'($urandom_range(0, 3)));
                1:       sw_write(2'(p), 1'b1, 8'($urandom), 1'b0);
                2:       cfg_dir(p, 8'($urandom));
                3:       bench_set(p, 8'($urandom));
                4:       pulse_irq($urandom_range(0, 1));
                5:       sw_write(2'd3, 1'b1, 8'($urandom), 1'b0);
                default: sw_write(2'd3, 1'b0, 8'($urandom), 1'b0);
            endcase
            settle_check($sformatf("rnd%0d", i));
        end

        cfg_dir(0, 8'hFF);
        sw_write(2'd0, 1'b1, 8'h5A, 1'b0);
        settle_check("pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int p = 0; p < 3; p++) begin
            m_dir[p] = 8'h00;
            m_out[p] = 8'h00;
        end
        m_bench[0] = 8'h5A;
        m_mask = 3'b000;
        m_pend = 3'b000;
        tb_oe  = 24'hFFFFFF;
        apply_bench();
        push(0, cyc, 24'h0, "rst_mid_led");
        push(2, cyc, 24'h0, "rst_mid_dir");
        sw = {1'b1, 2'd0, 1'b0, 4'h0, 8'hFF};
        m_sel = 2'd0;
        wait_cyc(3);
        rst_n = 1'b0;
        wait_cyc(8);
        push(2, cyc, 24'h0, "strb_thru_rst");
        settle_check("post_rst");
        sw[15] = 1'b0;
        wait_cyc(3);
        cfg_dir(1, 8'h3C);
        settle_check("post_rst_wr");

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d checks left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
